oc_dispatch_sched: RTL and testbench

Dispatch scheduler between the four-entry operand collector and the execution units. Each cycle it selects at most one ready collector entry for the ALU pipe and at most one for the MEM pipe, using independent round-robin priority. It drives the per-entry grant vectors that release collector entries. It also registers the selected entry ID so the EX stage can mux that entry's operand data. MEM issue is throttled by a credit counter that tracks outstanding memory requests.

---
 rtl/oc_dispatch_sched.sv | 150 +++++++++++++++
 tb/tb_oc_dispatch_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/oc_dispatch_sched.sv
// oc_dispatch_sched
// Dispatch scheduler between the four-entry operand collector and the ALU/MEM
// execution pipes. Each cycle it picks at most one ready entry per pipe with
// independent round-robin priority, releases the picked entries through the
// grant vectors, and registers the picked entry IDs for the EX stage.
// MEM issue is throttled by a credit counter of outstanding memory requests.
//
// Handshake: a grant bit is a one-cycle release of that collector entry. The
// collector drops RDY for the entry at the following edge, and EX sees
// Issue_Valid/Issue_OCID in that following cycle. There is no back-pressure
// path from EX other than ALU_Stall_Ex_Sched (ALU pipe) and the credit count
// (MEM pipe); both are judged on the current cycle's values only.
module oc_dispatch_sched #(
    parameter int MEM_CREDITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] RDY_OC_Sched,
    input  logic [3:0] MemOp_OC_Sched,
    input  logic       ALU_Stall_Ex_Sched,
    input  logic       MEM_Credit_Rtn_Sched,
    output logic [3:0] ALU_Grt_Sched_OC,
    output logic [3:0] MEM_Grt_Sched_OC,
    output logic       ALU_Issue_Valid_Sched_Ex,
    output logic [1:0] ALU_Issue_OCID_Sched_Ex,
    output logic       MEM_Issue_Valid_Sched_Ex,
    output logic [1:0] MEM_Issue_OCID_Sched_Ex,
    output logic [2:0] MEM_Credits_Sched
);

    localparam logic [2:0] CRED_MAX = 3'(MEM_CREDITS);

    logic [1:0] alu_ptr_q, alu_ptr_d;
    logic [1:0] mem_ptr_q, mem_ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       alu_vld_q, alu_vld_d;
    logic [1:0] alu_ocid_q, alu_ocid_d;
    logic       mem_vld_q, mem_vld_d;
    logic [1:0] mem_ocid_q, mem_ocid_d;

    logic [3:0] alu_cand, mem_cand;
    logic       alu_hit, mem_hit;
    logic [1:0] alu_idx, mem_idx;
    logic [1:0] alu_probe, mem_probe;
    logic [3:0] alu_grt, mem_grt;

    // Split ready entries into the two pipes; an entry belongs to exactly one.
    always_comb begin
        alu_cand = RDY_OC_Sched & ~MemOp_OC_Sched;
        mem_cand = RDY_OC_Sched & MemOp_OC_Sched;
    end

    // ALU round-robin: first candidate at or after alu_ptr, suppressed by stall/reset.
    always_comb begin
        alu_hit   = 1'b0;
        alu_idx   = alu_ptr_q;
        alu_probe = alu_ptr_q;
        alu_grt   = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            alu_probe = alu_ptr_q + 2'(k);
            if (!alu_hit && alu_cand[alu_probe]) begin
                alu_hit = 1'b1;
                alu_idx = alu_probe;
            end
        end
        if (!rst || ALU_Stall_Ex_Sched) begin
            alu_hit = 1'b0;
        end
        if (alu_hit) begin
            alu_grt[alu_idx] = 1'b1;
        end
    end

    // MEM round-robin: first candidate at or after mem_ptr, only with a credit in hand.
    always_comb begin
        mem_hit   = 1'b0;
        mem_idx   = mem_ptr_q;
        mem_probe = mem_ptr_q;
        mem_grt   = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            mem_probe = mem_ptr_q + 2'(k);
            if (!mem_hit && mem_cand[mem_probe]) begin
                mem_hit = 1'b1;
                mem_idx = mem_probe;
            end
        end
        if (!rst || (cnt_q == 3'd0)) begin
            mem_hit = 1'b0;
        end
        if (mem_hit) begin
            mem_grt[mem_idx] = 1'b1;
        end
    end

    // Next-state for pointers, credit count and issue registers.
    always_comb begin
        alu_ptr_d  = alu_ptr_q;
        mem_ptr_d  = mem_ptr_q;
        cnt_d      = cnt_q;
        alu_vld_d  = alu_hit;
        mem_vld_d  = mem_hit;
        alu_ocid_d = alu_ocid_q;
        mem_ocid_d = mem_ocid_q;
        if (alu_hit) begin
            alu_ptr_d  = alu_idx + 2'd1;
            alu_ocid_d = alu_idx;
        end
        if (mem_hit) begin
            mem_ptr_d  = mem_idx + 2'd1;
            mem_ocid_d = mem_idx;
        end
        // A grant paired with a return cancels out; a lone return saturates at
        // the maximum so stale returns from before a reset are absorbed.
        if (mem_hit && !MEM_Credit_Rtn_Sched) begin
            cnt_d = cnt_q - 3'd1;
        end else if (!mem_hit && MEM_Credit_Rtn_Sched && (cnt_q < CRED_MAX)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_ptr_q  <= 2'd0;
            mem_ptr_q  <= 2'd0;
            cnt_q      <= CRED_MAX;
            alu_vld_q  <= 1'b0;
            alu_ocid_q <= 2'd0;
            mem_vld_q  <= 1'b0;
            mem_ocid_q <= 2'd0;
        end else begin
            alu_ptr_q  <= alu_ptr_d;
            mem_ptr_q  <= mem_ptr_d;
            cnt_q      <= cnt_d;
            alu_vld_q  <= alu_vld_d;
            alu_ocid_q <= alu_ocid_d;
            mem_vld_q  <= mem_vld_d;
            mem_ocid_q <= mem_ocid_d;
        end
    end

    assign ALU_Grt_Sched_OC         = alu_grt;
    assign MEM_Grt_Sched_OC         = mem_grt;
    assign ALU_Issue_Valid_Sched_Ex = alu_vld_q;
    assign ALU_Issue_OCID_Sched_Ex  = alu_ocid_q;
    assign MEM_Issue_Valid_Sched_Ex = mem_vld_q;
    assign MEM_Issue_OCID_Sched_Ex  = mem_ocid_q;
    assign MEM_Credits_Sched        = cnt_q;

endmodule

// File: tb/tb_oc_dispatch_sched.sv
// Bench for oc_dispatch_sched: directed scenarios followed by random traffic,
// against a reference model of the scheduling rules with an issue scoreboard.
module tb_oc_dispatch_sched;

    localparam int CREDITS = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] rdy_in, memop_in;
    logic       stall_in, rtn_in;
    logic [3:0] alu_grt, mem_grt;
    logic       alu_vld, mem_vld;
    logic [1:0] alu_ocid, mem_ocid;
    logic [2:0] credits;

    oc_dispatch_sched #(.MEM_CREDITS(CREDITS)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .RDY_OC_Sched             (rdy_in),
        .MemOp_OC_Sched           (memop_in),
        .ALU_Stall_Ex_Sched       (stall_in),
        .MEM_Credit_Rtn_Sched     (rtn_in),
        .ALU_Grt_Sched_OC         (alu_grt),
        .MEM_Grt_Sched_OC         (mem_grt),
        .ALU_Issue_Valid_Sched_Ex (alu_vld),
        .ALU_Issue_OCID_Sched_Ex  (alu_ocid),
        .MEM_Issue_Valid_Sched_Ex (mem_vld),
        .MEM_Issue_OCID_Sched_Ex  (mem_ocid),
        .MEM_Credits_Sched        (credits)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard queues: expected issue IDs, one push per grant
    logic [1:0] exp_alu_q[$];
    logic [1:0] exp_mem_q[$];

    // reference model state
    int m_alu_ptr, m_mem_ptr, m_cnt, m_outstanding;
    int m_alu_last, m_mem_last;
    bit mon_en = 1'b0;

    // collector model driven by the bench
    logic [3:0] coll_rdy, coll_mem;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First index with a set bit, scanning start, start+1, ... modulo 4.
    function automatic int pick(input logic [3:0] cand, input int start);
        for (int k = 0; k < 4; k++) begin
            if (cand[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // driver: apply one cycle of inputs, check grants/credits, advance the model
    task automatic drive(input logic [3:0] rdy, input logic [3:0] mem,
                         input logic stall, input logic rtn, input logic rst_n,
                         output logic [3:0] eag, output logic [3:0] emg);
        int ea, em;
        @(negedge clk);
        rdy_in = rdy; memop_in = mem; stall_in = stall; rtn_in = rtn; rst = rst_n;
        #1;
        ea = -1; em = -1;
        if (rst_n) begin
            if (!stall) ea = pick(rdy & ~mem, m_alu_ptr);
            if (m_cnt > 0) em = pick(rdy & mem, m_mem_ptr);
        end
        eag = (ea >= 0) ? 4'(1 << ea) : 4'b0000;
        emg = (em >= 0) ? 4'(1 << em) : 4'b0000;
        check("alu_grant", int'(alu_grt), int'(eag));
        check("mem_grant", int'(mem_grt), int'(emg));
        check("credits", int'(credits), m_cnt);
        if (ea >= 0) exp_alu_q.push_back(2'(ea));
        if (em >= 0) exp_mem_q.push_back(2'(em));
        if (!rst_n) begin
            m_alu_ptr = 0; m_mem_ptr = 0; m_cnt = CREDITS; m_outstanding = 0;
            m_alu_last = 0; m_mem_last = 0;
        end else begin
            if (ea >= 0) m_alu_ptr = (ea + 1) % 4;
            if (em >= 0) m_mem_ptr = (em + 1) % 4;
            m_cnt = m_cnt - ((em >= 0) ? 1 : 0) + (rtn ? 1 : 0);
            if (m_cnt > CREDITS) m_cnt = CREDITS;
            if (em >= 0) m_outstanding++;
            if (rtn && m_outstanding > 0) m_outstanding--;
        end
    endtask

    // one cycle of the collector model; granted entries are released
    task automatic coll_cycle(input logic stall, input logic rtn);
        logic [3:0] eag, emg;
        drive(coll_rdy, coll_mem, stall, rtn, 1'b1, eag, emg);
        coll_rdy = coll_rdy & ~(eag | emg);
    endtask

    // monitor: every cycle the issue registers must match the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            check("alu_issue_valid", int'(alu_vld), (exp_alu_q.size() > 0) ? 1 : 0);
            if (exp_alu_q.size() > 0) begin
                logic [1:0] e;
                e = exp_alu_q.pop_front();
                if (alu_vld) check("alu_ocid", int'(alu_ocid), int'(e));
                m_alu_last = int'(e);
            end else begin
                check("alu_ocid_hold", int'(alu_ocid), m_alu_last);
            end
            check("mem_issue_valid", int'(mem_vld), (exp_mem_q.size() > 0) ? 1 : 0);
            if (exp_mem_q.size() > 0) begin
                logic [1:0] e;
                e = exp_mem_q.pop_front();
                if (mem_vld) check("mem_ocid", int'(mem_ocid), int'(e));
                m_mem_last = int'(e);
            end else begin
                check("mem_ocid_hold", int'(mem_ocid), m_mem_last);
            end
        end
    end

    initial begin
        logic [3:0] dga, dgm;
        rst = 1'b0; rdy_in = '0; memop_in = '0; stall_in = 1'b0; rtn_in = 1'b0;
        coll_rdy = '0; coll_mem = '0;
        m_alu_ptr = 0; m_mem_ptr = 0; m_cnt = CREDITS; m_outstanding = 0;
        m_alu_last = 0; m_mem_last = 0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // ALU round robin over four ready ALU entries
        coll_rdy = 4'b1111; coll_mem = 4'b0000;
        repeat (4) coll_cycle(1'b0, 1'b0);
        coll_cycle(1'b0, 1'b0);

        // simultaneous ALU and MEM grants
        coll_rdy = 4'b0101; coll_mem = 4'b0100;
        coll_cycle(1'b0, 1'b0);
        coll_cycle(1'b0, 1'b0);

        // credit exhaustion, return, grant+return
        while (m_cnt < CREDITS) coll_cycle(1'b0, 1'b1);
        coll_rdy = 4'b1111; coll_mem = 4'b1111;
        repeat (3) coll_cycle(1'b0, 1'b0);
        coll_cycle(1'b0, 1'b1);
        coll_cycle(1'b0, 1'b1);
        coll_cycle(1'b0, 1'b0);
        repeat (CREDITS) coll_cycle(1'b0, 1'b1);

        // returns at full credit saturate
        repeat (3) coll_cycle(1'b0, 1'b1);

        // ALU stall holds pointer; MEM unaffected
        coll_rdy = 4'b0011; coll_mem = 4'b0000;
        repeat (3) coll_cycle(1'b1, 1'b0);
        repeat (3) coll_cycle(1'b0, 1'b0);

        // mid-stream reset with alu_ptr=3 and credits drained
        while (m_cnt < CREDITS) coll_cycle(1'b0, 1'b1);
        coll_rdy = 4'b0111; coll_mem = 4'b0011;
        repeat (2) coll_cycle(1'b0, 1'b0);
        check("pre_reset_alu_ptr_model", m_alu_ptr, 3);
        check("pre_reset_credits_model", m_cnt, 0);
        drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, dga, dgm);
        coll_rdy = 4'b1111; coll_mem = 4'b0000;
        coll_cycle(1'b0, 1'b1);
        coll_cycle(1'b0, 1'b0);
        coll_rdy = 4'b0000;

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic st, rt;
            for (int i = 0; i < 4; i++) begin
                if (!coll_rdy[i] && $urandom_range(0, 1) == 1) begin
                    coll_rdy[i] = 1'b1;
                    coll_mem[i] = 1'($urandom_range(0, 1));
                end
            end
            st = ($urandom_range(0, 3) == 0);
            rt = (m_outstanding > 0 && $urandom_range(0, 1) == 1) ||
                 ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                drive(coll_rdy, coll_mem, st, rt, 1'b0, dga, dgm);
            end else begin
                coll_cycle(st, rt);
            end
        end
        coll_rdy = 4'b0000;
        repeat (2) coll_cycle(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
